// File: rtl/useq_pkg.sv
// Shared encodings and microword layout helpers for the microprogram sequencer.
package useq_pkg;

    // Sequencing operation carried in the top three bits of every microword.
    typedef enum logic [2:0] {
        OP_NEXT     = 3'd0,
        OP_JUMP     = 3'd1,
        OP_CJMP     = 3'd2,
        OP_CALL     = 3'd3,
        OP_RET      = 3'd4,
        OP_DISPATCH = 3'd5,
        OP_CCALL    = 3'd6,
        OP_HALT     = 3'd7
    } next_op_e;

    // Condition selector used by CJMP and CCALL.
    typedef enum logic [2:0] {
        COND_TRUE = 3'd0,
        COND_Z    = 3'd1,
        COND_N    = 3'd2,
        COND_C    = 3'd3,
        COND_V    = 3'd4,
        COND_NZ   = 3'd5,
        COND_NC   = 3'd6,
        COND_IRQ  = 3'd7
    } cond_sel_e;

    // Run/halt state of the sequencer.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

    // Microword layout, LSB first: ctl, target, cond_sel, next_op.
    localparam int NEXT_OP_W  = 3;
    localparam int COND_SEL_W = 3;
    localparam int SEQ_W      = NEXT_OP_W + COND_SEL_W;
    localparam int CTL_LSB    = 0;

    // Bit positions inside the datapath flag vector {V,C,N,Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    function automatic int uwordWidth(input int uaW, input int ctlW);
        return SEQ_W + uaW + ctlW;
    endfunction

    function automatic int targetLsb(input int ctlW);
        return CTL_LSB + ctlW;
    endfunction

    function automatic int condLsb(input int uaW, input int ctlW);
        return CTL_LSB + ctlW + uaW;
    endfunction

    function automatic int opLsb(input int uaW, input int ctlW);
        return CTL_LSB + ctlW + uaW + COND_SEL_W;
    endfunction

    // Resolves the branch condition from the flags present in the fetch cycle.
    function automatic logic evalCond(input cond_sel_e sel, input logic [3:0] flags,
                                      input logic irq);
        logic c;
        case (sel)
            COND_TRUE: c = 1'b1;
            COND_Z:    c = flags[FLAG_Z];
            COND_N:    c = flags[FLAG_N];
            COND_C:    c = flags[FLAG_C];
            COND_V:    c = flags[FLAG_V];
            COND_NZ:   c = ~flags[FLAG_Z];
            COND_NC:   c = ~flags[FLAG_C];
            COND_IRQ:  c = irq;
            default:   c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/useq_if.sv
// Bundle between the sequencer and its ROMs / datapath.
// master is the sequencer side, slave is the ROM/datapath side.
interface useq_if import useq_pkg::*; #(
    parameter int UA_WIDTH  = 8,
    parameter int CTL_WIDTH = 24
) ();

    localparam int UWORD_W = uwordWidth(UA_WIDTH, CTL_WIDTH);

    logic [UA_WIDTH-1:0]  uaddr;
    logic [UWORD_W-1:0]   uword;
    logic [UA_WIDTH-1:0]  dispatch_addr;
    logic [3:0]           flags;
    logic                 irq;
    logic                 mem_wait;
    logic [CTL_WIDTH-1:0] ctl_out;
    logic                 halted;
    logic                 stack_err;

    modport master (
        output uaddr, ctl_out, halted, stack_err,
        input  uword, dispatch_addr, flags, irq, mem_wait
    );

    modport slave (
        input  uaddr, ctl_out, halted, stack_err,
        output uword, dispatch_addr, flags, irq, mem_wait
    );

endinterface

// File: rtl/useq_ustack.sv
// Circular micro-return stack. A push into a full stack overwrites the
// oldest entry, so the most recent STACK_DEPTH return addresses survive.
// STACK_DEPTH must be a power of two, at least 2.
module ustack #(
    parameter int UA_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [UA_WIDTH-1:0] data_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [UA_WIDTH-1:0] top_o
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(STACK_DEPTH);

    logic [UA_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [PTR_W-1:0]    sp_q;
    logic [PTR_W-1:0]    topIdx;
    logic [CNT_W-1:0]    cnt_q;

    assign full_o  = (cnt_q == DEPTH_CNT);
    assign empty_o = (cnt_q == '0);
    assign topIdx  = sp_q - PTR_W'(1);
    assign top_o   = mem_q[topIdx];

    // Pointer/occupancy update; entries are written only outside reset so a
    // call interrupted by reset commits nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            mem_q[sp_q] <= data_i;
            sp_q        <= sp_q + PTR_W'(1);
            if (!full_o) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            sp_q  <= sp_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/useq.sv
// Microprogram sequencer: holds the micro-PC, decodes the sequencing fields
// of the returned microword, picks the next micro-address with no delay slot
// and registers the control field for the datapath one cycle later.
module useq import useq_pkg::*; #(
    parameter int                  UA_WIDTH    = 8,
    parameter int                  CTL_WIDTH   = 24,
    parameter int                  STACK_DEPTH = 4,
    parameter logic [UA_WIDTH-1:0] RESET_UADDR = '0,
    parameter logic [UA_WIDTH-1:0] IRQ_UADDR   = 8'hF0
) (
    input logic    clk,
    input logic    rst_n,
    useq_if.master bus
);

    localparam int TARGET_LSB = targetLsb(CTL_WIDTH);
    localparam int COND_LSB   = condLsb(UA_WIDTH, CTL_WIDTH);
    localparam int OP_LSB     = opLsb(UA_WIDTH, CTL_WIDTH);

    logic [UA_WIDTH-1:0]  uaddr_q, uaddr_d;
    logic [CTL_WIDTH-1:0] ctl_q, ctl_d;
    seq_state_e           state_q, state_d;
    logic                 stackErr_q, stackErr_d;

    next_op_e             op;
    cond_sel_e            condSel;
    logic [UA_WIDTH-1:0]  target;
    logic [CTL_WIDTH-1:0] ctlField;
    logic [UA_WIDTH-1:0]  uaddrInc;
    logic                 condTrue;

    logic                 push;
    logic                 pop;
    logic                 stkFull;
    logic                 stkEmpty;
    logic [UA_WIDTH-1:0]  stkTop;

    assign op       = next_op_e'(bus.uword[OP_LSB +: NEXT_OP_W]);
    assign condSel  = cond_sel_e'(bus.uword[COND_LSB +: COND_SEL_W]);
    assign target   = bus.uword[TARGET_LSB +: UA_WIDTH];
    assign ctlField = bus.uword[CTL_LSB +: CTL_WIDTH];
    assign uaddrInc = uaddr_q + UA_WIDTH'(1);
    assign condTrue = evalCond(condSel, bus.flags, bus.irq);

    ustack #(
        .UA_WIDTH    (UA_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (uaddrInc),
        .full_o  (stkFull),
        .empty_o (stkEmpty),
        .top_o   (stkTop)
    );

    // Next-address, control and halt selection; a stall freezes everything.
    always_comb begin
        uaddr_d    = uaddr_q;
        ctl_d      = ctl_q;
        state_d    = state_q;
        stackErr_d = stackErr_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (!bus.mem_wait) begin
            if (state_q == ST_HALT) begin
                ctl_d = '0;
                if (bus.irq) begin
                    uaddr_d = IRQ_UADDR;
                    state_d = ST_RUN;
                end
            end else begin
                ctl_d = ctlField;
                case (op)
                    OP_NEXT:     uaddr_d = uaddrInc;
                    OP_JUMP:     uaddr_d = target;
                    OP_CJMP:     uaddr_d = condTrue ? target : uaddrInc;
                    OP_CALL: begin
                        push    = 1'b1;
                        uaddr_d = target;
                    end
                    OP_RET: begin
                        pop     = 1'b1;
                        uaddr_d = stkEmpty ? RESET_UADDR : stkTop;
                    end
                    OP_DISPATCH: uaddr_d = bus.dispatch_addr;
                    OP_CCALL: begin
                        push    = condTrue;
                        uaddr_d = condTrue ? target : uaddrInc;
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                        ctl_d   = '0;
                    end
                    default:     uaddr_d = uaddrInc;
                endcase
                stackErr_d = stackErr_q | (push & stkFull) | (pop & stkEmpty);
            end
        end
    end

    // Micro-PC, control register, run/halt state and sticky stack error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uaddr_q    <= RESET_UADDR;
            ctl_q      <= '0;
            state_q    <= ST_RUN;
            stackErr_q <= 1'b0;
        end else begin
            uaddr_q    <= uaddr_d;
            ctl_q      <= ctl_d;
            state_q    <= state_d;
            stackErr_q <= stackErr_d;
        end
    end

    assign bus.uaddr     = uaddr_q;
    assign bus.ctl_out   = ctl_q;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.stack_err = stackErr_q;

endmodule

// File: tb/tb_useq.sv
// Self-checking bench for the microprogram sequencer: a ROM array answers
// uaddr combinationally, a behavioural model predicts every cycle into a
// scoreboard queue, and a vector table covers single-step decode cases.
module tb_useq;
    import useq_pkg::*;

    localparam int         UA_W   = 8;
    localparam int         CTL_W  = 24;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] RST_UA = 8'h00;
    localparam logic [7:0] IRQ_UA = 8'hF0;

    typedef struct {
        logic [7:0]  uaddr;
        logic [23:0] ctl;
        logic        halted;
        logic        err;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  cs;
        logic [7:0]  tg;
        logic [3:0]  flg;
        logic        irq;
        logic [7:0]  disp;
        logic [23:0] ctl;
        logic [7:0]  expUa;
        logic [23:0] expCtl;
        logic        expHalt;
        logic        expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [37:0] rom [256];
    exp_t        sbQ [$];
    vec_t        vecs [$];
    int          checks = 0;
    int          failures = 0;

    logic [7:0]  mUa;
    logic [23:0] mCtl;
    logic        mHalt;
    logic        mErr;
    logic [7:0]  mStack [$];

    useq_if #(.UA_WIDTH(UA_W), .CTL_WIDTH(CTL_W)) bus ();

    useq #(
        .UA_WIDTH    (UA_W),
        .CTL_WIDTH   (CTL_W),
        .STACK_DEPTH (DEPTH),
        .RESET_UADDR (RST_UA),
        .IRQ_UADDR   (IRQ_UA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.uword = rom[bus.uaddr];

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [37:0] mkWord(input logic [2:0] op, input logic [2:0] cs,
                                           input logic [7:0] tg, input logic [23:0] ctl);
        return {op, cs, tg, ctl};
    endfunction

    function automatic logic [23:0] ctlOf(input logic [7:0] a);
        return {8'hC3, a, ~a};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fillRom();
        for (int i = 0; i < 256; i++) begin
            rom[i] = mkWord(OP_NEXT, COND_TRUE, 8'h00, ctlOf(8'(i)));
        end
    endtask

    task automatic place(input logic [7:0] a, input logic [2:0] op, input logic [2:0] cs,
                         input logic [7:0] tg);
        rom[a] = mkWord(op, cs, tg, ctlOf(a));
    endtask

    function automatic void modelPush(input logic [7:0] a);
        if (mStack.size() == DEPTH) begin
            void'(mStack.pop_front());
            mErr = 1'b1;
        end
        mStack.push_back(a);
    endfunction

    function automatic logic [7:0] modelPop();
        if (mStack.size() == 0) begin
            mErr = 1'b1;
            return RST_UA;
        end
        return mStack.pop_back();
    endfunction

    // Behavioural prediction of the state after the coming rising edge.
    task automatic modelStep(output exp_t e);
        logic [37:0] w;
        logic [2:0]  op;
        logic [2:0]  cs;
        logic [7:0]  tg;
        logic [7:0]  inc;
        logic        c;
        w   = rom[mUa];
        op  = w[37:35];
        cs  = w[34:32];
        tg  = w[31:24];
        inc = mUa + 8'd1;
        case (cs)
            3'd0:    c = 1'b1;
            3'd1:    c = bus.flags[0];
            3'd2:    c = bus.flags[1];
            3'd3:    c = bus.flags[2];
            3'd4:    c = bus.flags[3];
            3'd5:    c = !bus.flags[0];
            3'd6:    c = !bus.flags[2];
            default: c = bus.irq;
        endcase
        if (bus.mem_wait) begin
        end else if (mHalt) begin
            mCtl = '0;
            if (bus.irq) begin
                mUa   = IRQ_UA;
                mHalt = 1'b0;
            end
        end else begin
            mCtl = w[23:0];
            case (op)
                3'd0: mUa = inc;
                3'd1: mUa = tg;
                3'd2: mUa = c ? tg : inc;
                3'd3: begin modelPush(inc); mUa = tg; end
                3'd4: mUa = modelPop();
                3'd5: mUa = bus.dispatch_addr;
                3'd6: begin
                    if (c) begin modelPush(inc); mUa = tg; end
                    else mUa = inc;
                end
                default: begin mHalt = 1'b1; mCtl = '0; end
            endcase
        end
        e = '{mUa, mCtl, mHalt, mErr};
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_underflow actual=empty required=entry");
        end else begin
            e = sbQ.pop_front();
            checkVal("sb_uaddr", 32'(bus.uaddr), 32'(e.uaddr));
            checkVal("sb_ctl", 32'(bus.ctl_out), 32'(e.ctl));
            checkVal("sb_halted", 32'(bus.halted), 32'(e.halted));
            checkVal("sb_stack_err", 32'(bus.stack_err), 32'(e.err));
        end
    endtask

    task automatic stepExpect(input exp_t e);
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus();
        exp_t e;
        modelStep(e);
        stepExpect(e);
    endtask

    task automatic doReset();
        bus.mem_wait      = 1'b0;
        bus.irq           = 1'b0;
        bus.flags         = 4'h0;
        bus.dispatch_addr = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkVal("rst_uaddr", 32'(bus.uaddr), 32'(RST_UA));
        checkVal("rst_ctl", 32'(bus.ctl_out), 32'h0);
        checkVal("rst_halted", 32'(bus.halted), 32'h0);
        checkVal("rst_stack_err", 32'(bus.stack_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mUa   = RST_UA;
        mCtl  = '0;
        mHalt = 1'b0;
        mErr  = 1'b0;
        mStack.delete();
        sbQ.delete();
        #1;
        checkVal("release_ctl", 32'(bus.ctl_out), 32'h0);
    endtask

    task automatic addVec(input logic [2:0] op, input logic [2:0] cs, input logic [7:0] tg,
                          input logic [3:0] flg, input logic irq, input logic [7:0] disp,
                          input logic [7:0] expUa, input logic expHalt, input logic expErr);
        vec_t v;
        v.op      = op;
        v.cs      = cs;
        v.tg      = tg;
        v.flg     = flg;
        v.irq     = irq;
        v.disp    = disp;
        v.ctl     = 24'h5A0000 | 24'(vecs.size());
        v.expUa   = expUa;
        v.expCtl  = expHalt ? 24'h0 : v.ctl;
        v.expHalt = expHalt;
        v.expErr  = expErr;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        bus.mem_wait      = 1'b0;
        bus.irq           = 1'b0;
        bus.flags         = 4'h0;
        bus.dispatch_addr = 8'h00;
        fillRom();

        // Single-step decode table, each vector executed from address 0 after reset.
        addVec(OP_NEXT,     COND_TRUE, 8'h00, 4'b0000, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        addVec(OP_JUMP,     COND_TRUE, 8'h55, 4'b0000, 1'b0, 8'h00, 8'h55, 1'b0, 1'b0);
        addVec(OP_CJMP,     COND_Z,    8'h40, 4'b0001, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0);
        addVec(OP_CJMP,     COND_Z,    8'h40, 4'b0000, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        addVec(OP_CJMP,     COND_N,    8'h40, 4'b0010, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0);
        addVec(OP_CJMP,     COND_C,    8'h40, 4'b1011, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        addVec(OP_CJMP,     COND_V,    8'h40, 4'b1000, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0);
        addVec(OP_CJMP,     COND_NZ,   8'h40, 4'b0000, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0);
        addVec(OP_CJMP,     COND_NC,   8'h40, 4'b0100, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        addVec(OP_CJMP,     COND_IRQ,  8'h40, 4'b0000, 1'b1, 8'h00, 8'h40, 1'b0, 1'b0);
        addVec(OP_CJMP,     COND_TRUE, 8'h40, 4'b0000, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0);
        addVec(OP_DISPATCH, COND_TRUE, 8'h11, 4'b0000, 1'b0, 8'h7A, 8'h7A, 1'b0, 1'b0);
        addVec(OP_CCALL,    COND_Z,    8'h33, 4'b0000, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        addVec(OP_CCALL,    COND_Z,    8'h33, 4'b0001, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0);
        addVec(OP_CALL,     COND_TRUE, 8'h22, 4'b0000, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0);
        addVec(OP_RET,      COND_TRUE, 8'h44, 4'b0000, 1'b0, 8'h00, RST_UA, 1'b0, 1'b1);
        addVec(OP_HALT,     COND_TRUE, 8'h44, 4'b0000, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            doReset();
            fillRom();
            rom[0]            = mkWord(vecs[i].op, vecs[i].cs, vecs[i].tg, vecs[i].ctl);
            bus.flags         = vecs[i].flg;
            bus.irq           = vecs[i].irq;
            bus.dispatch_addr = vecs[i].disp;
            e = '{vecs[i].expUa, vecs[i].expCtl, vecs[i].expHalt, vecs[i].expErr};
            stepExpect(e);
            bus.irq = 1'b0;
        end

        // Straight-line NEXT through the whole space, wrapping back to zero.
        doReset();
        fillRom();
        for (int i = 0; i < 256; i++) begin
            applyStimulus();
        end
        checkVal("wrap_uaddr", 32'(bus.uaddr), 32'h00);
        checkVal("wrap_ctl", 32'(bus.ctl_out), 32'(ctlOf(8'hFF)));
        checkVal("wrap_err", 32'(bus.stack_err), 32'h0);

        // Nested calls 05->20, 21->30, then two returns.
        doReset();
        fillRom();
        place(8'h00, OP_JUMP, COND_TRUE, 8'h05);
        place(8'h05, OP_CALL, COND_TRUE, 8'h20);
        place(8'h21, OP_CALL, COND_TRUE, 8'h30);
        place(8'h30, OP_RET,  COND_TRUE, 8'h00);
        place(8'h22, OP_RET,  COND_TRUE, 8'h00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
        end
        checkVal("nest_ret1", 32'(bus.uaddr), 32'h22);
        applyStimulus();
        checkVal("nest_ret2", 32'(bus.uaddr), 32'h06);
        checkVal("nest_err", 32'(bus.stack_err), 32'h0);

        // Five calls overflow the four-entry stack; the fifth return underflows.
        doReset();
        fillRom();
        place(8'h00, OP_CALL, COND_TRUE, 8'h10);
        place(8'h10, OP_CALL, COND_TRUE, 8'h20);
        place(8'h20, OP_CALL, COND_TRUE, 8'h30);
        place(8'h30, OP_CALL, COND_TRUE, 8'h40);
        place(8'h40, OP_CALL, COND_TRUE, 8'h50);
        place(8'h50, OP_RET,  COND_TRUE, 8'h00);
        place(8'h41, OP_RET,  COND_TRUE, 8'h00);
        place(8'h31, OP_RET,  COND_TRUE, 8'h00);
        place(8'h21, OP_RET,  COND_TRUE, 8'h00);
        place(8'h11, OP_RET,  COND_TRUE, 8'h00);
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
        end
        checkVal("ovf_ret4", 32'(bus.uaddr), 32'h11);
        applyStimulus();
        checkVal("ovf_ret5", 32'(bus.uaddr), 32'(RST_UA));
        checkVal("ovf_err", 32'(bus.stack_err), 32'h1);
        applyStimulus();
        checkVal("err_sticky", 32'(bus.stack_err), 32'h1);

        // HALT, irq exit, re-halt, irq exit deferred by mem_wait.
        doReset();
        fillRom();
        place(8'h00, OP_JUMP, COND_TRUE, 8'h60);
        place(8'h60, OP_HALT, COND_TRUE, 8'h00);
        place(8'hF0, OP_JUMP, COND_TRUE, 8'h60);
        applyStimulus();
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
        end
        checkVal("halt_flag", 32'(bus.halted), 32'h1);
        checkVal("halt_ctl", 32'(bus.ctl_out), 32'h0);
        checkVal("halt_uaddr", 32'(bus.uaddr), 32'h60);
        bus.irq = 1'b1;
        applyStimulus();
        bus.irq = 1'b0;
        checkVal("irq_uaddr", 32'(bus.uaddr), 32'(IRQ_UA));
        checkVal("irq_halted", 32'(bus.halted), 32'h0);
        applyStimulus();
        applyStimulus();
        bus.irq      = 1'b1;
        bus.mem_wait = 1'b1;
        applyStimulus();
        applyStimulus();
        checkVal("wait_irq_uaddr", 32'(bus.uaddr), 32'h60);
        checkVal("wait_irq_halted", 32'(bus.halted), 32'h1);
        bus.mem_wait = 1'b0;
        applyStimulus();
        bus.irq = 1'b0;
        checkVal("late_irq_uaddr", 32'(bus.uaddr), 32'(IRQ_UA));
        checkVal("late_irq_halted", 32'(bus.halted), 32'h0);

        // Stall mid-sequence, then reset during the stall.
        doReset();
        fillRom();
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
        end
        bus.mem_wait = 1'b1;
        applyStimulus();
        applyStimulus();
        checkVal("stall_uaddr", 32'(bus.uaddr), 32'h04);
        checkVal("stall_ctl", 32'(bus.ctl_out), 32'(ctlOf(8'h03)));
        rst_n = 1'b0;
        #1;
        checkVal("stall_rst_uaddr", 32'(bus.uaddr), 32'(RST_UA));
        checkVal("stall_rst_ctl", 32'(bus.ctl_out), 32'h0);
        bus.mem_wait = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mUa   = RST_UA;
        mCtl  = '0;
        mHalt = 1'b0;
        mErr  = 1'b0;
        mStack.delete();
        applyStimulus();
        checkVal("post_rst_uaddr", 32'(bus.uaddr), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
